uart_rx_cfg: RTL and testbench

Configurable UART receiver: converts an asynchronous serial line into parallel words for the transceiver datapath. Compared with the basic 8N1 receiver it adds parametrised word width, parity and stop-bit count, an input synchroniser, a ready/valid output with a holding register, and per-word parity, framing and overrun status. It sits between the pad-side RX pin and the receive FIFO or consumer logic.

---
 rtl/uart_rx_cfg.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised rx, oversampled mid-bit sampling,
// optional parity / two stop bits, ready/valid holding register with error status.
module uart_rx_cfg #(
    parameter int CLOCK_RATE  = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  rx,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CLK_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int CW          = $clog2(CLK_PER_BIT);
    localparam int BW          = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] HALF      = CW'((CLK_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [CW-1:0]           r_clk_cnt;
    logic [BW-1:0]           r_bit_cnt;
    logic                    r_stop_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_p_err;
    logic                    r_f_err;
    logic                    r_m_valid;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic                    r_parity_err;
    logic                    r_frame_err;
    logic                    r_overrun;
    logic                    w_rxs;
    logic                    w_bit_end;
    logic                    w_f_err_final;
    logic                    w_deliver;

    // Resetting to 1 makes the chain look like an idle line.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_sync <= '1;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end

    assign w_rxs         = r_sync[SYNC_STAGES-1];
    assign w_bit_end     = (r_clk_cnt == LAST_CLK);
    assign w_f_err_final = r_f_err | ~w_rxs;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_deliver    = 1'b0;
        case (r_state)
            S_IDLE:      if (!w_rxs) w_state_next = S_START;
            S_START:     if (r_clk_cnt == HALF) w_state_next = w_rxs ? S_IDLE : S_DATA;
            S_DATA:      if (w_bit_end && r_bit_cnt == LAST_BIT)
                             w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (w_bit_end) w_state_next = S_STOP;
            S_STOP: begin
                if (w_bit_end && r_stop_cnt == LAST_STOP) begin
                    w_deliver    = 1'b1;
                    // A low stop bit may be a break: wait for the line to recover.
                    w_state_next = w_f_err_final ? S_WAIT_HIGH : S_IDLE;
                end
            end
            S_WAIT_HIGH: if (w_rxs) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_p_err    <= 1'b0;
            r_f_err    <= 1'b0;
        end else begin
            case (r_state)
                S_START: r_clk_cnt <= (r_clk_cnt == HALF) ? '0 : r_clk_cnt + 1'b1;
                S_DATA, S_PARITY, S_STOP: begin
                    r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
                    if (w_bit_end) begin
                        if (r_state == S_DATA) begin
                            r_shift[r_bit_cnt] <= w_rxs;
                            r_bit_cnt          <= r_bit_cnt + 1'b1;
                        end else if (r_state == S_PARITY) begin
                            r_p_err <= (^r_shift ^ w_rxs) != (PARITY == 1);
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                            r_f_err    <= w_f_err_final;
                        end
                    end
                end
                default: begin
                    r_clk_cnt  <= '0;
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= 1'b0;
                    r_p_err    <= 1'b0;
                    r_f_err    <= 1'b0;
                end
            endcase
        end
    end

    // A new word is only accepted if the holding register is empty or draining this cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_deliver) begin
            if (!r_m_valid || m_ready) begin
                r_m_valid    <= 1'b1;
                r_m_data     <= r_shift;
                r_parity_err <= r_p_err;
                r_frame_err  <= w_f_err_final;
                r_overrun    <= 1'b0;
            end else begin
                r_overrun    <= 1'b1;
            end
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 10 clocks per bit,
// directed frames push expected words, a monitor thread pops them on every handshake.
module tb_uart_rx_cfg;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk  = 1'b0;
    logic       arst = 1'b1;
    logic       rx_l [3];
    logic       mr_l [3];
    logic       mv_l [3];
    logic       pe_l [3];
    logic       fe_l [3];
    logic       ov_l [3];
    logic       bz_l [3];
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000)) u_8n1 (
        .clk(clk), .arst(arst), .rx(rx_l[0]), .m_valid(mv_l[0]), .m_ready(mr_l[0]),
        .m_data(d0), .parity_err(pe_l[0]), .frame_err(fe_l[0]), .overrun(ov_l[0]), .busy(bz_l[0])
    );

    uart_rx_cfg #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(7), .PARITY(2)) u_7e1 (
        .clk(clk), .arst(arst), .rx(rx_l[1]), .m_valid(mv_l[1]), .m_ready(mr_l[1]),
        .m_data(d1), .parity_err(pe_l[1]), .frame_err(fe_l[1]), .overrun(ov_l[1]), .busy(bz_l[1])
    );

    uart_rx_cfg #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .arst(arst), .rx(rx_l[2]), .m_valid(mv_l[2]), .m_ready(mr_l[2]),
        .m_data(d2), .parity_err(pe_l[2]), .frame_err(fe_l[2]), .overrun(ov_l[2]), .busy(bz_l[2])
    );

    function automatic logic [8:0] dat(input int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {2'b0, d1};
            default: return {1'b0, d2};
        endcase
    endfunction

    task automatic expect_word(input int i, input logic [8:0] d, input logic pe,
                               input logic fe, input logic ov);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.ov = ov;
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int i, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (i)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("check %s = 0x%0h ok", name, act);
        end
    endtask

    task automatic drive_bit(input int i, input logic v);
        rx_l[i] = v;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [8:0] data, input int dw,
                              input bit has_par, input logic par,
                              input int nstop, input logic [1:0] stops);
        drive_bit(i, 1'b0);
        for (int k = 0; k < dw; k++) drive_bit(i, data[k]);
        if (has_par) drive_bit(i, par);
        for (int k = 0; k < nstop; k++) drive_bit(i, stops[k]);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_l[i] = 1'b1;
            mr_l[i] = 1'b1;
        end
        fork
            // Monitor: every handshake consumes one expected word.
            begin
                exp_t got, e;
                bit   ok;
                while (!done) begin
                    @(negedge clk);
                    for (int i = 0; i < 3; i++) begin
                        if (!arst && mv_l[i] && mr_l[i]) begin
                            got.data = dat(i); got.pe = pe_l[i];
                            got.fe = fe_l[i];  got.ov = ov_l[i];
                            pop_exp(i, e, ok);
                            n_cmp++;
                            if (!ok) begin
                                n_bad++;
                                $display("FAIL word_u%0d: unexpected word data=0x%0h, expected none",
                                         i, got.data);
                            end else if (got !== e) begin
                                n_bad++;
                                $display("FAIL word_u%0d: got data=0x%0h pe=%0b fe=%0b ov=%0b, expected data=0x%0h pe=%0b fe=%0b ov=%0b",
                                         i, got.data, got.pe, got.fe, got.ov, e.data, e.pe, e.fe, e.ov);
                            end else begin
                                $display("word u%0d data=0x%0h pe=%0b fe=%0b ov=%0b ok",
                                         i, got.data, got.pe, got.fe, got.ov);
                            end
                        end
                    end
                end
            end
            // Stimulus
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("rst_valid", 32'(mv_l[0]), 0);
                chk("rst_data", 32'(d0), 0);
                chk("rst_overrun", 32'(ov_l[0]), 0);
                chk("rst_busy", 32'(bz_l[0]), 0);
                @(posedge clk); #1;
                arst = 1'b0;
                repeat (5) @(posedge clk);
                #1;

                // 8N1 back-to-back
                expect_word(0, 9'h0A5, 0, 0, 0);
                expect_word(0, 9'h03C, 0, 0, 0);
                send_frame(0, 9'h0A5, 8, 0, 0, 1, 2'b01);
                send_frame(0, 9'h03C, 8, 0, 0, 1, 2'b01);
                drive_bit(0, 1'b1);

                // 7E1: 0x55 has four ones, so even parity bit is 0
                expect_word(1, 9'h055, 0, 0, 0);
                expect_word(1, 9'h055, 1, 0, 0);
                send_frame(1, 9'h055, 7, 1, 1'b0, 1, 2'b01);
                send_frame(1, 9'h055, 7, 1, 1'b1, 1, 2'b01);
                drive_bit(1, 1'b1);

                // 8N2: second stop low, then a 30-bit break
                expect_word(2, 9'h081, 0, 1, 0);
                send_frame(2, 9'h081, 8, 0, 0, 2, 2'b01);
                for (int k = 0; k < 30; k++) drive_bit(2, 1'b0);
                @(negedge clk);
                chk("break_busy", 32'(bz_l[2]), 1);
                chk("break_valid", 32'(mv_l[2]), 0);
                @(posedge clk); #1;
                drive_bit(2, 1'b1);
                drive_bit(2, 1'b1);
                @(negedge clk);
                chk("break_end_busy", 32'(bz_l[2]), 0);
                @(posedge clk); #1;
                expect_word(2, 9'h012, 0, 0, 0);
                send_frame(2, 9'h012, 8, 0, 0, 2, 2'b11);
                drive_bit(2, 1'b1);

                // Overrun: consumer stalled for three words
                mr_l[0] = 1'b0;
                expect_word(0, 9'h011, 0, 0, 1);
                send_frame(0, 9'h011, 8, 0, 0, 1, 2'b01);
                send_frame(0, 9'h022, 8, 0, 0, 1, 2'b01);
                send_frame(0, 9'h033, 8, 0, 0, 1, 2'b01);
                drive_bit(0, 1'b1);
                @(negedge clk);
                chk("ovr_valid", 32'(mv_l[0]), 1);
                chk("ovr_data", 32'(d0), 32'h11);
                chk("ovr_flag", 32'(ov_l[0]), 1);
                @(posedge clk); #1;
                mr_l[0] = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                chk("ovr_clear", 32'(ov_l[0]), 0);
                chk("ovr_valid_clear", 32'(mv_l[0]), 0);
                expect_word(0, 9'h044, 0, 0, 0);
                send_frame(0, 9'h044, 8, 0, 0, 1, 2'b01);
                drive_bit(0, 1'b1);

                // 3-cycle glitch on idle line
                rx_l[0] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rx_l[0] = 1'b1;
                @(negedge clk);
                chk("glitch_busy_hi", 32'(bz_l[0]), 1);
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk("glitch_idle", 32'(bz_l[0]), 0);
                chk("glitch_valid", 32'(mv_l[0]), 0);
                @(posedge clk); #1;

                // Reset in the middle of data bit 3 of 0x5A
                drive_bit(0, 1'b0);
                drive_bit(0, 1'b0);
                drive_bit(0, 1'b1);
                drive_bit(0, 1'b0);
                rx_l[0] = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                chk("mid_busy", 32'(bz_l[0]), 1);
                arst = 1'b1;
                @(negedge clk);
                chk("arst_busy", 32'(bz_l[0]), 0);
                chk("arst_data", 32'(d0), 0);
                chk("arst_valid", 32'(mv_l[0]), 0);
                chk("arst_overrun", 32'(ov_l[0]), 0);
                @(posedge clk); #1;
                arst = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                expect_word(0, 9'h05A, 0, 0, 0);
                send_frame(0, 9'h05A, 8, 0, 0, 1, 2'b01);
                drive_bit(0, 1'b1);
                drive_bit(0, 1'b1);

                chk("drain_u0", 32'(q0.size()), 0);
                chk("drain_u1", 32'(q1.size()), 0);
                chk("drain_u2", 32'(q2.size()), 0);
                done = 1'b1;
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
